// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction fetch stage: FSM encodings,
// bubble instruction default and register-field positions in an instruction word.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  localparam int RN_MSB = 19;
  localparam int RN_LSB = 16;
  localparam int RM_MSB = 3;
  localparam int RM_LSB = 0;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds when load_en=0, otherwise captures either the
// fetched word with its PC+4 or a bubble (NOP, pc4=0, invalid).
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  // Enable-controlled capture with bubble insert
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_INSTR;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (load_en) begin
      if (bubble) begin
        instr <= NOP_INSTR;
        pc4   <= 32'h0;
        valid <= 1'b0;
      end else begin
        instr <= instr_in;
        pc4   <= pc4_in;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, fetch FSM, stall counter and the IF/ID
// register instance.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_BOOT | single cycle after reset release, no fetch accepted
// ST_RUN  | fetching; PC advances whenever memory and both enables allow
// ST_WAIT | memory not ready; PC held, bubbles fed to ID until imem_rdy
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        le_pc,
  input  logic        le_if_id,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rdy,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [3:0]  id_rn,
  output logic [3:0]  id_rm,
  output logic [15:0] stall_cnt
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         booting;
  logic         take_br;
  logic         fetch_ok;
  logic         ifid_load;
  logic         ifid_bubble;

  // Fetch/redirect decisions; a branch seen while ID is held is dropped
  always_comb begin
    pc_plus4    = pc + 32'd4;
    booting     = (state == ST_BOOT);
    take_br     = branch_taken & le_if_id & ~booting;
    // Both enables are required so a word is never fetched without a place to land
    fetch_ok    = ~booting & ~take_br & imem_rdy & le_pc & le_if_id;
    ifid_load   = le_if_id & ~booting;
    // Any non-fetch load (redirect, memory wait, PC hold) inserts a bubble
    ifid_bubble = ~fetch_ok;
  end

  // FSM, PC and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_BOOT;
      pc        <= RESET_PC;
      stall_cnt <= 16'h0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN, ST_WAIT: begin
          if (take_br) begin
            state <= ST_RUN;
            pc    <= branch_target;
          end else begin
            state <= imem_rdy ? ST_RUN : ST_WAIT;
            if (fetch_ok) pc <= pc_plus4;
          end
          if (!take_br && !fetch_ok && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (ifid_load),
    .bubble   (ifid_bubble),
    .instr_in (imem_rdata),
    .pc4_in   (pc_plus4),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

  assign imem_addr = pc;
  assign id_rn     = if_id_instr[RN_MSB:RN_LSB];
  assign id_rm     = if_id_instr[RM_MSB:RM_LSB];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage. Memory model returns the
// address as data, optionally XORed with a pattern to exercise id_rn/id_rm.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        le_pc;
  logic        le_if_id;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rdy;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [3:0]  id_rn;
  logic [3:0]  id_rm;
  logic [15:0] stall_cnt;

  logic [31:0] mem_xor;
  int          n_checks;
  int          n_fail;

  if_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .le_pc         (le_pc),
    .le_if_id      (le_if_id),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_rdy      (imem_rdy),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .id_rn         (id_rn),
    .id_rm         (id_rm),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb imem_rdata = imem_addr ^ mem_xor;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected %h", imem_addr, 32'h0); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", if_id_valid); end
    n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_stall: got %h expected 0", stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // BOOT cycle: nothing fetched
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b expected 0", if_id_valid); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL boot_addr: got %h expected 0", imem_addr); end
    n_checks++; if (dut.state !== ST_RUN) begin n_fail++; $display("FAIL boot_state: got %0d expected %0d", dut.state, ST_RUN); end
  endtask

  task automatic test_run();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (if_id_instr !== 32'(4*i)) begin n_fail++; $display("FAIL run_instr%0d: got %h expected %h", i, if_id_instr, 32'(4*i)); end
      n_checks++; if (if_id_pc4 !== 32'(4*i+4)) begin n_fail++; $display("FAIL run_pc4%0d: got %h expected %h", i, if_id_pc4, 32'(4*i+4)); end
      n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL run_valid%0d: got %b expected 1", i, if_id_valid); end
    end
    step();
    n_checks++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL run_addr: got %h expected 10", imem_addr); end
  endtask

  task automatic test_load_use();
    le_pc = 1'b0; le_if_id = 1'b0;
    step();
    n_checks++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL lu_addr: got %h expected 10", imem_addr); end
    n_checks++; if (if_id_instr !== 32'hC) begin n_fail++; $display("FAIL lu_instr: got %h expected c", if_id_instr); end
    n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL lu_valid: got %b expected 1", if_id_valid); end
    n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall: got %0d expected 1", stall_cnt); end
    le_pc = 1'b1; le_if_id = 1'b1;
    step();
    n_checks++; if (if_id_instr !== 32'h10 || if_id_pc4 !== 32'h14) begin n_fail++; $display("FAIL lu_resume: got %h/%h expected 10/14", if_id_instr, if_id_pc4); end
    step(); step(); step();
    n_checks++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL lu_addr20: got %h expected 20", imem_addr); end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid: got %b expected 0", if_id_valid); end
    n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL br_addr: got %h expected 100", imem_addr); end
    n_checks++; if (if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin n_fail++; $display("FAIL br_bubble: got %h/%h expected 0/0", if_id_instr, if_id_pc4); end
    n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL br_stall: got %0d expected 1", stall_cnt); end
    step();
    n_checks++; if (if_id_instr !== 32'h100 || if_id_pc4 !== 32'h104 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL br_target: got %h/%h/%b expected 100/104/1", if_id_instr, if_id_pc4, if_id_valid); end
  endtask

  task automatic test_branch_held();
    branch_taken = 1'b1; branch_target = 32'h200; le_if_id = 1'b0;
    step();
    n_checks++; if (imem_addr !== 32'h104) begin n_fail++; $display("FAIL brh_addr: got %h expected 104", imem_addr); end
    n_checks++; if (if_id_instr !== 32'h100) begin n_fail++; $display("FAIL brh_instr: got %h expected 100", if_id_instr); end
    n_checks++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL brh_stall: got %0d expected 2", stall_cnt); end
    branch_taken = 1'b0; le_if_id = 1'b1;
    step();
    n_checks++; if (if_id_instr !== 32'h104 || imem_addr !== 32'h108) begin n_fail++; $display("FAIL brh_resume: got %h/%h expected 104/108", if_id_instr, imem_addr); end
    // redirect to 0x40 for the memory wait scenario
    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    n_checks++; if (imem_addr !== 32'h40 || stall_cnt !== 16'd2) begin n_fail++; $display("FAIL brh_redir: got %h/%0d expected 40/2", imem_addr, stall_cnt); end
  endtask

  task automatic test_wait();
    imem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (dut.state !== ST_WAIT) begin n_fail++; $display("FAIL wait_state%0d: got %0d expected %0d", i, dut.state, ST_WAIT); end
      n_checks++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL wait_hold%0d: got %b/%h expected 0/40", i, if_id_valid, imem_addr); end
      n_checks++; if (stall_cnt !== 16'(3 + i)) begin n_fail++; $display("FAIL wait_stall%0d: got %0d expected %0d", i, stall_cnt, 3 + i); end
    end
    imem_rdy = 1'b1;
    step();
    n_checks++; if (if_id_instr !== 32'h40 || if_id_pc4 !== 32'h44 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL wait_done: got %h/%h/%b expected 40/44/1", if_id_instr, if_id_pc4, if_id_valid); end
    n_checks++; if (dut.state !== ST_RUN || imem_addr !== 32'h44) begin n_fail++; $display("FAIL wait_run: got %0d/%h expected %0d/44", dut.state, imem_addr, ST_RUN); end
  endtask

  task automatic test_fields();
    mem_xor = 32'h000A_0007;
    step();
    n_checks++; if (if_id_instr !== 32'h000A_0043) begin n_fail++; $display("FAIL fld_instr: got %h expected 000a0043", if_id_instr); end
    n_checks++; if (id_rn !== 4'hA || id_rm !== 4'h3) begin n_fail++; $display("FAIL fld_rnrm: got %h/%h expected a/3", id_rn, id_rm); end
    mem_xor = 32'h0;
  endtask

  task automatic test_wait_branch_reset();
    imem_rdy = 1'b0;
    step();
    n_checks++; if (stall_cnt !== 16'd6) begin n_fail++; $display("FAIL wb_stall: got %0d expected 6", stall_cnt); end
    branch_taken = 1'b1; branch_target = 32'h80;
    step();
    branch_taken = 1'b0;
    n_checks++; if (imem_addr !== 32'h80 || dut.state !== ST_RUN || stall_cnt !== 16'd6) begin n_fail++; $display("FAIL wb_redir: got %h/%0d/%0d expected 80/%0d/6", imem_addr, dut.state, stall_cnt, ST_RUN); end
    step();
    n_checks++; if (dut.state !== ST_WAIT || stall_cnt !== 16'd7) begin n_fail++; $display("FAIL wb_wait: got %0d/%0d expected %0d/7", dut.state, stall_cnt, ST_WAIT); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'h0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL ar_outs: got %h/%h/%h/%b expected 0/0/0/0", imem_addr, if_id_instr, if_id_pc4, if_id_valid); end
    n_checks++; if (stall_cnt !== 16'h0 || dut.state !== ST_BOOT) begin n_fail++; $display("FAIL ar_state: got %0d/%0d expected 0/%0d", stall_cnt, dut.state, ST_BOOT); end
    imem_rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_boot: got %b/%h expected 0/0", if_id_valid, imem_addr); end
    step();
    n_checks++; if (if_id_instr !== 32'h0 || if_id_pc4 !== 32'h4 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL ar_first: got %h/%h/%b expected 0/4/1", if_id_instr, if_id_pc4, if_id_valid); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; le_pc = 1'b1; le_if_id = 1'b1; branch_taken = 1'b0;
    branch_target = 32'h0; imem_rdy = 1'b1; mem_xor = 32'h0;
    test_reset();
    test_run();
    test_load_use();
    test_branch();
    test_branch_held();
    test_wait();
    test_fields();
    test_wait_branch_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, the instruction word placed in IF/ID for a bubble.
REQ-003 SHALL have port clk  input  1  the single rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port le_pc  input  1  PC load enable from the hazard/forwarding unit; 0 means hold.
REQ-006 SHALL have port le_if_id  input  1  IF/ID load enable from the hazard/forwarding unit; 0 means hold.
REQ-007 SHALL have port branch_taken  input  1  ID-stage resolved taken branch.
REQ-008 SHALL have port branch_target  input  32  ID-stage branch destination address.
REQ-009 SHALL have port imem_addr  output  32  instruction memory address, equal to the current PC.
REQ-010 SHALL have port imem_rdata  input  32  instruction memory read data.
REQ-011 SHALL have port imem_rdy  input  1  read data valid this cycle.
REQ-012 SHALL have port if_id_instr  output  32  registered instruction.
REQ-013 SHALL have port if_id_pc4  output  32  registered PC+4 of that instruction.
REQ-014 SHALL have port if_id_valid  output  1  1 = real instruction, 0 = bubble.
REQ-015 SHALL have port id_rn  output  4  if_id_instr[19:16], fed to the hazard/forwarding unit.
REQ-016 SHALL have port id_rm  output  4  if_id_instr[3:0], fed to the hazard/forwarding unit.
REQ-017 SHALL have port stall_cnt  output  16  count of cycles in which the PC did not advance.

Function
REQ-018 SHALL implement FSM states BOOT, RUN and WAIT.
REQ-019 SHALL have BOOT last exactly one cycle after reset release: no fetch is accepted, IF/ID stays invalid, and the FSM moves to RUN.
REQ-020 SHALL, in RUN with imem_rdy=1, le_pc=1 and le_if_id=1, load IF/ID with {imem_rdata, PC+4, valid=1} and set PC to PC+4 (mod 2^32), giving one-cycle latency from imem_addr to if_id_instr.
REQ-021 SHALL define take_br = branch_taken & le_if_id, so a branch is ignored while ID is held.
REQ-022 SHALL, on take_br in any state except BOOT, set PC to branch_target, load IF/ID with {NOP_INSTR, 0, valid=0}, discard the fetched word, and set the FSM to RUN.
REQ-023 SHALL give take_br priority over imem_rdy and le_pc.
REQ-024 SHALL, when le_pc=0, hold PC; when le_if_id=0, hold all IF/ID fields; each enable acts independently.
REQ-025 SHALL, with le_pc=1 and le_if_id=0, still hold PC so that no fetched word is lost.
REQ-026 SHALL, in RUN with imem_rdy=0 and no take_br, hold PC, load a bubble into IF/ID if le_if_id=1, and enter WAIT.
REQ-027 SHALL stay in WAIT while imem_rdy=0, then on imem_rdy=1 behave as REQ-020 and return to RUN.
REQ-028 SHALL increment stall_cnt by 1, saturating at 16'hFFFF, in every post-BOOT cycle in which PC neither advances nor is redirected.
REQ-029 SHALL drive imem_addr, id_rn and id_rm combinationally from registers only.

Reset
REQ-030 SHALL, while rst_n=0, force PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, stall_cnt=0 and FSM=BOOT, independent of clk.
REQ-031 SHALL, on reset asserted mid-WAIT or mid-branch, discard all pending state and restart from BOOT.

Structure
REQ-032 SHALL take FSM state encodings, NOP_INSTR default and the register-field bit positions from the shared pipeline package.
REQ-033 SHALL instantiate one sub-module, if_id_reg, holding the enable-controlled IF/ID register with bubble insert; PC and FSM stay in the top module.

Verification
REQ-034 SHALL cover reset and run: release rst_n with imem_rdy=1 and memory word = address -> BOOT one cycle, then if_id_instr = 0, 4, 8 on consecutive cycles with if_id_pc4 = 4, 8, 12.
REQ-035 SHALL cover a load-use stall: le_pc=0, le_if_id=0 for 1 cycle at PC=0x10 -> PC, IF/ID and if_id_valid unchanged for that cycle, stall_cnt=1.
REQ-036 SHALL cover a branch: branch_taken=1, branch_target=0x100 at PC=0x20 -> next cycle if_id_valid=0 and PC=0x100; the following cycle if_id_instr = mem[0x100].
REQ-037 SHALL cover a branch while ID is held: branch_taken=1, le_if_id=0 -> branch ignored and PC unchanged.
REQ-038 SHALL cover a memory wait: imem_rdy=0 for 3 cycles at PC=0x40 -> WAIT for 3 cycles, bubbles in IF/ID, stall_cnt += 3, then mem[0x40] loaded.
REQ-039 SHALL cover reset during WAIT: rst_n=0 asynchronously mid-cycle -> all outputs at reset values immediately, FSM=BOOT.
